// File: rtl/sw_pkg.sv
// Shared definitions for the T-line SRAM responder.
// Holds the geometry of the packed {t, v, f} word, the header field layout,
// the responder FSM state type and a helper that finds the last word index.
package sw_pkg;

    localparam int unsigned V_E_F_BIT      = 12;
    localparam int unsigned VF_W           = V_E_F_BIT - 1;
    localparam int unsigned BIT_P_GROUP    = 2 + 2 * VF_W;
    localparam int unsigned T_PER_WORD     = 4;
    localparam int unsigned HEADER_BIT     = 4;
    localparam int unsigned CNT_W          = HEADER_BIT - 1;
    localparam int unsigned PAY_W          = BIT_P_GROUP * T_PER_WORD;
    localparam int unsigned SRAM_WORD      = HEADER_BIT + PAY_W;
    localparam int unsigned MAX_T_SIZE_LOG = 10;
    localparam int unsigned DEPTH          = 256;
    localparam int unsigned ADDR_W         = $clog2(DEPTH);
    localparam int unsigned NWORDS_W       = MAX_T_SIZE_LOG + 1;
    localparam int unsigned DP_LIMIT       = 64;

    // Header field offsets inside an SRAM word
    localparam int unsigned HDR_VALID_POS  = SRAM_WORD - 1;
    localparam int unsigned HDR_CNT_MSB    = SRAM_WORD - 2;
    localparam int unsigned HDR_CNT_LSB    = PAY_W;

    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] count;
        logic [PAY_W-1:0] payload;
    } sram_word_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    // Index of the last word of a line: ceil(t_size / T_PER_WORD) - 1
    function automatic logic [ADDR_W-1:0] last_word_idx(input logic [MAX_T_SIZE_LOG-1:0] t_size);
        logic [NWORDS_W-1:0] nwords;
        nwords = (NWORDS_W'(t_size) + NWORDS_W'(T_PER_WORD - 1)) / NWORDS_W'(T_PER_WORD);
        return ADDR_W'(nwords - NWORDS_W'(1));
    endfunction

endpackage

// File: rtl/t_word_packer.sv
// Accumulates T load beats into MSB-first packed words of {t, v=0, f=0} groups.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   clear_i      - discard any partial word
//   beat_i       - one load beat this cycle
//   t_i          - T base for the beat
//   last_i       - this beat is the final element of the line
//   word_c_o     - word including the current beat (unused groups zero)
//   count_c_o    - header count for the word (0 = full)
//   flush_c_o    - write strobe: word is full or the line ends this beat
module t_word_packer
    import sw_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             beat_i,
    input  logic [1:0]       t_i,
    input  logic             last_i,
    output logic [PAY_W-1:0] word_c_o,
    output logic [CNT_W-1:0] count_c_o,
    output logic             flush_c_o
);

    logic [PAY_W-1:0]       buf_q, buf_d;
    logic [CNT_W-1:0]       gidx_q, gidx_d;
    logic [BIT_P_GROUP-1:0] group_c;
    logic                   full_c;

    // Merge the current beat into its slot of the partial word
    always_comb begin
        group_c  = {t_i, {(BIT_P_GROUP - 2){1'b0}}};
        word_c_o = buf_q;
        for (int g = 0; g < int'(T_PER_WORD); g++) begin
            if (gidx_q == CNT_W'(g)) begin
                word_c_o[int'(PAY_W) - 1 - g * int'(BIT_P_GROUP) -: BIT_P_GROUP] = group_c;
            end
        end
        full_c    = (gidx_q == CNT_W'(T_PER_WORD - 1));
        flush_c_o = beat_i & (last_i | full_c);
        count_c_o = (last_i & ~full_c) ? gidx_q + CNT_W'(1) : '0;
    end

    always_comb begin
        buf_d  = buf_q;
        gidx_d = gidx_q;
        if (clear_i) begin
            buf_d  = '0;
            gidx_d = '0;
        end else if (beat_i) begin
            if (flush_c_o) begin
                buf_d  = '0;
                gidx_d = '0;
            end else begin
                buf_d  = word_c_o;
                gidx_d = gidx_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            gidx_q <= '0;
        end else begin
            buf_q  <= buf_d;
            gidx_q <= gidx_d;
        end
    end

endmodule

// File: rtl/sram_t_line_store.sv
// Responder end of the T-line SRAM protocol: loads one packed T line, serves
// word reads to the data processor, absorbs rewritten words, reloads on i_init.
// Optional macro SRAM_T_HAZARD_CHECK_EN adds per-word lap tags and o_hazard.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   i_T_size                      - number of T elements in the line
//   i_load_valid, i_load_t        - load beat and its T base
//   o_load_ready / o_ready        - in LOAD / in SERVE
//   i_request, o_request_data     - word read request and one-cycle response
//   i_send, i_send_data           - write-back of one word (payload only)
//   i_init                        - job done, return to LOAD
//   o_hazard (optional)           - sticky: a word was read before being rewritten
module sram_t_line_store
    import sw_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MAX_T_SIZE_LOG-1:0] i_T_size,
    input  logic                      i_load_valid,
    input  logic [1:0]                i_load_t,
    output logic                      o_load_ready,
    output logic                      o_ready,
    input  logic                      i_request,
    output logic [SRAM_WORD-1:0]      o_request_data,
    input  logic                      i_send,
    input  logic [SRAM_WORD-1:0]      i_send_data,
    input  logic                      i_init
`ifdef SRAM_T_HAZARD_CHECK_EN
    ,
    output logic                      o_hazard
`endif
);

    state_e                    state_q, state_d;
    logic [MAX_T_SIZE_LOG-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, last_word;
    logic                      resp_q, resp_prev_q;
    logic [SRAM_WORD-1:0]      rdata_q, rdata_d;
    logic                      load_ready_q, ready_q;
    logic                      load_beat_c, last_beat_c, accept_c, send_c, init_c;
    logic [PAY_W-1:0]          pk_word;
    logic [CNT_W-1:0]          pk_count;
    logic                      pk_flush;
    logic                      mem_we;
    logic [PAY_W-1:0]          mem_wdata;
    sram_word_t                resp_word;
    logic                      unused_hdr;

    logic [PAY_W-1:0]          mem_q     [DEPTH];
    logic [CNT_W-1:0]          cnt_mem_q [DEPTH];

    assign last_word  = last_word_idx(i_T_size);
    assign unused_hdr = ^i_send_data[HDR_VALID_POS:HDR_CNT_LSB];

    t_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == ST_SERVE),
        .beat_i    (load_beat_c),
        .t_i       (i_load_t),
        .last_i    (last_beat_c),
        .word_c_o  (pk_word),
        .count_c_o (pk_count),
        .flush_c_o (pk_flush)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (last_beat_c) state_d = ST_SERVE;
            ST_SERVE: if (i_init)      state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    // FSM control outputs; a read is refused while a response is shown or was just shown
    always_comb begin
        load_beat_c = 1'b0;
        last_beat_c = 1'b0;
        accept_c    = 1'b0;
        send_c      = 1'b0;
        init_c      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_beat_c = i_load_valid & (i_T_size != '0);
                last_beat_c = load_beat_c & (beat_q == i_T_size - MAX_T_SIZE_LOG'(1));
            end
            ST_SERVE: begin
                init_c   = i_init;
                accept_c = i_request & ~resp_q & ~resp_prev_q & ~i_init;
                send_c   = i_send & ~i_init;
            end
            default: ;
        endcase
    end

    // Beat counter and read/write pointers
    always_comb begin
        beat_d   = beat_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (state_q == ST_LOAD) begin
            rd_ptr_d = '0;
            if (load_beat_c) beat_d = last_beat_c ? '0 : beat_q + MAX_T_SIZE_LOG'(1);
            if (pk_flush)    wr_ptr_d = last_beat_c ? '0 : wr_ptr_q + ADDR_W'(1);
        end else if (init_c) begin
            beat_d   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (accept_c) rd_ptr_d = (rd_ptr_q == last_word) ? '0 : rd_ptr_q + ADDR_W'(1);
            if (send_c)   wr_ptr_d = (wr_ptr_q == last_word) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        resp_word.valid   = 1'b1;
        resp_word.count   = cnt_mem_q[rd_ptr_q];
        resp_word.payload = mem_q[rd_ptr_q];
        rdata_d           = accept_c ? resp_word : '0;
        mem_we            = pk_flush | send_c;
        mem_wdata         = send_c ? i_send_data[PAY_W-1:0] : pk_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            resp_q       <= 1'b0;
            resp_prev_q  <= 1'b0;
            rdata_q      <= '0;
            load_ready_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            resp_q       <= accept_c;
            resp_prev_q  <= resp_q;
            rdata_q      <= rdata_d;
            load_ready_q <= (state_d == ST_LOAD);
            ready_q      <= (state_d == ST_SERVE);
        end
    end

    // Storage is not reset; counts only change when a line is loaded
    always_ff @(posedge clk) begin
        if (mem_we)   mem_q[wr_ptr_q]     <= mem_wdata;
        if (pk_flush) cnt_mem_q[wr_ptr_q] <= pk_count;
    end

    assign o_load_ready   = load_ready_q;
    assign o_ready        = ready_q;
    assign o_request_data = rdata_q;

`ifdef SRAM_T_HAZARD_CHECK_EN
    logic tag_q [DEPTH];
    logic rd_lap_q, rd_lap_d, wr_lap_q, wr_lap_d, hazard_q, hazard_d;

    // Loaded words carry tag 1; a read in lap r expects the tag written in lap r-1
    always_comb begin
        rd_lap_d = rd_lap_q;
        wr_lap_d = wr_lap_q;
        hazard_d = hazard_q;
        if (state_q == ST_LOAD || init_c) begin
            rd_lap_d = 1'b0;
            wr_lap_d = 1'b0;
            if (init_c) hazard_d = 1'b0;
        end else begin
            if (accept_c && rd_ptr_q == last_word) rd_lap_d = ~rd_lap_q;
            if (send_c && wr_ptr_q == last_word)   wr_lap_d = ~wr_lap_q;
            if (accept_c && (tag_q[rd_ptr_q] != ~rd_lap_q)) hazard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_lap_q <= 1'b0;
            wr_lap_q <= 1'b0;
            hazard_q <= 1'b0;
        end else begin
            rd_lap_q <= rd_lap_d;
            wr_lap_q <= wr_lap_d;
            hazard_q <= hazard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) tag_q[wr_ptr_q] <= send_c ? wr_lap_q : 1'b1;
    end

    assign o_hazard = hazard_q;
`endif

endmodule

// File: tb/tb_sram_t_line_store.sv
// Directed self-checking bench for sram_t_line_store.
module tb_sram_t_line_store;
    import sw_pkg::*;

    logic                      clk;
    logic                      rst_n;
    logic [MAX_T_SIZE_LOG-1:0] i_T_size;
    logic                      i_load_valid;
    logic [1:0]                i_load_t;
    logic                      o_load_ready;
    logic                      o_ready;
    logic                      i_request;
    logic [SRAM_WORD-1:0]      o_request_data;
    logic                      i_send;
    logic [SRAM_WORD-1:0]      i_send_data;
    logic                      i_init;
`ifdef SRAM_T_HAZARD_CHECK_EN
    logic                      o_hazard;
`endif

    int n_checks;
    int n_fail;

    sram_t_line_store dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_T_size       (i_T_size),
        .i_load_valid   (i_load_valid),
        .i_load_t       (i_load_t),
        .o_load_ready   (o_load_ready),
        .o_ready        (o_ready),
        .i_request      (i_request),
        .o_request_data (o_request_data),
        .i_send         (i_send),
        .i_send_data    (i_send_data),
        .i_init         (i_init)
`ifdef SRAM_T_HAZARD_CHECK_EN
        ,
        .o_hazard       (o_hazard)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SRAM_WORD-1:0] got, input logic [SRAM_WORD-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_line(input int n, input int base);
        i_T_size = MAX_T_SIZE_LOG'(n);
        for (int i = 0; i < n; i++) begin
            i_load_valid = 1'b1;
            i_load_t     = 2'((base + i) % 4);
            step();
            if (i == n - 2) chk("ready_before_last_beat", SRAM_WORD'(o_ready), SRAM_WORD'(0));
        end
        i_load_valid = 1'b0;
        chk("ready_after_last_beat", SRAM_WORD'(o_ready), SRAM_WORD'(1));
        chk("load_ready_in_serve", SRAM_WORD'(o_load_ready), SRAM_WORD'(0));
    endtask

    // One request; response must appear for exactly one cycle, then wait out the blackout
    task automatic req(input string tag, input logic [SRAM_WORD-1:0] exp);
        i_request = 1'b1;
        step();
        i_request = 1'b0;
        chk(tag, o_request_data, exp);
        step();
        chk({tag, "_gap"}, o_request_data, SRAM_WORD'(0));
        step();
    endtask

    task automatic send(input logic [SRAM_WORD-1:0] data);
        i_send      = 1'b1;
        i_send_data = data;
        step();
        i_send      = 1'b0;
    endtask

    logic [SRAM_WORD-1:0] w0, w2, r0, r1, wa, wb, wc, wd, sa, sb, sc, sd;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        i_T_size     = '0;
        i_load_valid = 1'b0;
        i_load_t     = '0;
        i_request    = 1'b0;
        i_send       = 1'b0;
        i_send_data  = '0;
        i_init       = 1'b0;

        // Line of 10 elements, t = i % 4
        w0 = {4'h8, 96'h000000_400000_800000_C00000};
        w2 = {4'hA, 96'h000000_400000_000000_000000};
        // Line of 5 elements starting at base 1
        r0 = {4'h8, 96'h400000_800000_C00000_000000};
        r1 = {4'h9, 96'h400000_000000_000000_000000};
        // Write-back payloads; header bits driven with junk
        sa = {4'h7, 96'h111111_222222_333333_444444};
        sb = {4'h5, 96'hABCDEF_012345_6789AB_CDEF01};
        sc = {4'hF, 96'h0F0F0F_F0F0F0_55AA55_AA55AA};
        sd = {4'h3, 96'hDEADBE_EFCAFE_BABE12_345678};
        wa = {4'h8, sa[PAY_W-1:0]};
        wb = {4'h8, sb[PAY_W-1:0]};
        wc = {4'hA, sc[PAY_W-1:0]};
        wd = {4'h8, sd[PAY_W-1:0]};

        step();
        step();
        chk("reset_load_ready", SRAM_WORD'(o_load_ready), SRAM_WORD'(1));
        chk("reset_ready", SRAM_WORD'(o_ready), SRAM_WORD'(0));
        chk("reset_rdata", o_request_data, SRAM_WORD'(0));
        rst_n = 1'b1;
        step();

        load_line(10, 0);
        req("rd_w0", w0);
        req("rd_w1", w0);
        req("rd_w2_count2", w2);

        // Request held for three cycles yields one response
        i_request = 1'b1;
        step();
        chk("held_resp", o_request_data, w0);
        step();
        chk("held_gap1", o_request_data, SRAM_WORD'(0));
        step();
        chk("held_gap2", o_request_data, SRAM_WORD'(0));
        i_request = 1'b0;
        req("after_blackout", w0);
        req("rd_w2_again", w2);

        // Write back a full lap, then read it back in order
        send(sa);
        send(sb);
        send(sc);
        req("rd_sent_a", wa);
        req("rd_sent_b", wb);
        req("rd_sent_c", wc);

        // Same-cycle read and write of word 0 returns old data
        i_request   = 1'b1;
        i_send      = 1'b1;
        i_send_data = sd;
        step();
        i_request = 1'b0;
        i_send    = 1'b0;
        chk("same_addr_old", o_request_data, wa);
        step();
        step();
        req("rd_b_next_lap", wb);
        req("rd_c_next_lap", wc);
        req("same_addr_new", wd);

        // Init with a request in the same cycle: no response, back to LOAD
        i_request = 1'b1;
        i_init    = 1'b1;
        step();
        i_request = 1'b0;
        i_init    = 1'b0;
        chk("init_drop_resp", o_request_data, SRAM_WORD'(0));
        chk("init_load_ready", SRAM_WORD'(o_load_ready), SRAM_WORD'(1));
        chk("init_ready_low", SRAM_WORD'(o_ready), SRAM_WORD'(0));
        step();
        chk("init_no_late_resp", o_request_data, SRAM_WORD'(0));

        // Zero-length line never leaves LOAD
        i_T_size     = '0;
        i_load_valid = 1'b1;
        step();
        step();
        i_load_valid = 1'b0;
        step();
        chk("tsize0_ready", SRAM_WORD'(o_ready), SRAM_WORD'(0));
        chk("tsize0_load_ready", SRAM_WORD'(o_load_ready), SRAM_WORD'(1));

        load_line(5, 1);
        req("reload_w0", r0);
        req("reload_w1_count1", r1);

`ifdef SRAM_T_HAZARD_CHECK_EN
        i_init = 1'b1;
        step();
        i_init = 1'b0;
        step();
        load_line(8, 0);
        req("hz_rd_w0", w0);
        req("hz_rd_w1", w0);
        chk("hz_clear_lap0", SRAM_WORD'(o_hazard), SRAM_WORD'(0));
        req("hz_rd_w0_lap1", w0);
        chk("hz_set", SRAM_WORD'(o_hazard), SRAM_WORD'(1));
        step();
        step();
        chk("hz_sticky", SRAM_WORD'(o_hazard), SRAM_WORD'(1));
        i_init = 1'b1;
        step();
        i_init = 1'b0;
        chk("hz_cleared_by_init", SRAM_WORD'(o_hazard), SRAM_WORD'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
